sad_min_tracker: RTL and testbench

//  Consumes the final SAD adder-tree result, one candidate search position per transfer.

---
 rtl/sad_pkg.sv | 14 +
 rtl/sad_pos_counter.sv | 47 ++++
 rtl/sad_min_tracker.sv | 136 +++++++++++++
 tb/tb_sad_min_tracker.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/sad_pkg.sv
// Package sad_pkg: shared definitions for the SAD adder tree and result stages.
//   SAD_W_DEF   - default SAD width
//   sad_state_t - result-stage FSM state encoding (IDLE=0, SCAN=1, DONE=2)
package sad_pkg;

  localparam int SAD_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } sad_state_t;

endpackage

// File: rtl/sad_pos_counter.sv
// sad_pos_counter: raster-order (row, col) position counter for the SAD scan.
// Ports:
//   clk, rst_n  - clock (rising edge), asynchronous active-low reset
//   clear       - force position to (0,0)
//   advance     - step one position (col first, wrapping into row)
//   row, col    - current position
//   last        - current position is (FRAME_ROWS-1, FRAME_COLS-1)
module sad_pos_counter #(
  parameter int FRAME_ROWS = 4,
  parameter int FRAME_COLS = 4,
  parameter int ROW_W      = 2,
  parameter int COL_W      = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             advance,
  output logic [ROW_W-1:0] row,
  output logic [COL_W-1:0] col,
  output logic             last
);

  logic row_last;
  logic col_last;

  assign row_last = (row == ROW_W'(FRAME_ROWS - 1));
  assign col_last = (col == COL_W'(FRAME_COLS - 1));
  assign last     = row_last && col_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row <= '0;
      col <= '0;
    end else if (clear) begin
      row <= '0;
      col <= '0;
    end else if (advance) begin
      if (col_last) begin
        col <= '0;
        row <= row_last ? '0 : row + ROW_W'(1);
      end else begin
        col <= col + COL_W'(1);
      end
    end
  end

endmodule

// File: rtl/sad_min_tracker.sv
// sad_min_tracker: motion-vector result stage. Consumes one SAD per candidate
// position in raster order over a FRAME_ROWS x FRAME_COLS window, tracks the
// minimum SAD and its position, and pulses Done once the scan completes.
// Ports:
//   Clk, Reset         - clock (rising edge), asynchronous active-low reset
//   Start              - begin a scan (only honoured in IDLE)
//   SadValid, SadIn    - incoming SAD; transfer = SadValid & SadReady
//   SadReady           - high while scanning
//   Busy               - high in SCAN and DONE
//   Done               - one-cycle pulse after the final transfer
//   MinSad/MinRow/MinCol - minimum SAD and its position
// Optional feature (macro SAD_EARLY_EXIT_EN):
//   Threshold (in), EarlyExit (out) - a SAD below Threshold ends the scan early.
module sad_min_tracker
  import sad_pkg::*;
#(
  parameter int SAD_W      = SAD_W_DEF,
  parameter int FRAME_ROWS = 4,
  parameter int FRAME_COLS = 4,
  parameter int ROW_W      = 2,
  parameter int COL_W      = 2
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             SadValid,
  input  logic [SAD_W-1:0] SadIn,
`ifdef SAD_EARLY_EXIT_EN
  input  logic [SAD_W-1:0] Threshold,
  output logic             EarlyExit,
`endif
  output logic             SadReady,
  output logic             Busy,
  output logic             Done,
  output logic [SAD_W-1:0] MinSad,
  output logic [ROW_W-1:0] MinRow,
  output logic [COL_W-1:0] MinCol
);

  sad_state_t       state;
  logic             first;
  logic             xfer;
  logic             better;
  logic             hit;
  logic             finish;
  logic             pos_last;
  logic [ROW_W-1:0] pos_row;
  logic [COL_W-1:0] pos_col;

  assign SadReady = (state == ST_SCAN);
  assign xfer     = SadValid && SadReady;
  // Strict compare keeps the earliest position on ties.
  assign better   = first || (SadIn < MinSad);

`ifdef SAD_EARLY_EXIT_EN
  // Any earlier SAD was >= Threshold, so a hit is always also the new minimum.
  assign hit = (SadIn < Threshold);
`else
  assign hit = 1'b0;
`endif

  assign finish = pos_last || hit;

  sad_pos_counter #(
    .FRAME_ROWS (FRAME_ROWS),
    .FRAME_COLS (FRAME_COLS),
    .ROW_W      (ROW_W),
    .COL_W      (COL_W)
  ) u_pos (
    .clk     (Clk),
    .rst_n   (Reset),
    .clear   ((state == ST_IDLE) && Start),
    .advance (xfer),
    .row     (pos_row),
    .col     (pos_col),
    .last    (pos_last)
  );

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state     <= ST_IDLE;
      first     <= 1'b1;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      MinSad    <= '0;
      MinRow    <= '0;
      MinCol    <= '0;
`ifdef SAD_EARLY_EXIT_EN
      EarlyExit <= 1'b0;
`endif
    end else begin
      Done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (Start) begin
            state     <= ST_SCAN;
            first     <= 1'b1;
            Busy      <= 1'b1;
`ifdef SAD_EARLY_EXIT_EN
            EarlyExit <= 1'b0;
`endif
          end
        end
        ST_SCAN: begin
          if (xfer) begin
            first <= 1'b0;
            if (better) begin
              MinSad <= SadIn;
              MinRow <= pos_row;
              MinCol <= pos_col;
            end
            if (finish) begin
              state     <= ST_DONE;
              Done      <= 1'b1;
`ifdef SAD_EARLY_EXIT_EN
              EarlyExit <= hit;
`endif
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          Busy  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          Busy  <= 1'b0;
        end
      endcase
    end
  end

  logic unused_hit;
  assign unused_hit = hit;

endmodule

// File: tb/tb_sad_min_tracker.sv
// Directed testbench for sad_min_tracker with a 2 x 3 candidate window.
module tb_sad_min_tracker;

  localparam int SW = 16;

  logic          Clk = 1'b0;
  logic          Reset = 1'b0;
  logic          Start = 1'b0;
  logic          SadValid = 1'b0;
  logic [SW-1:0] SadIn = '0;
  logic          SadReady, Busy, Done;
  logic [SW-1:0] MinSad;
  logic [0:0]    MinRow;
  logic [1:0]    MinCol;
`ifdef SAD_EARLY_EXIT_EN
  logic [SW-1:0] Threshold = '0;
  logic          EarlyExit;
`endif

  int vectors = 0;
  int miscompares = 0;
  int done_cnt = 0;

  always #5 Clk = ~Clk;
  always @(negedge Clk) if (Done === 1'b1) done_cnt++;

  sad_min_tracker #(
    .SAD_W      (SW),
    .FRAME_ROWS (2),
    .FRAME_COLS (3),
    .ROW_W      (1),
    .COL_W      (2)
  ) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Start     (Start),
    .SadValid  (SadValid),
    .SadIn     (SadIn),
`ifdef SAD_EARLY_EXIT_EN
    .Threshold (Threshold),
    .EarlyExit (EarlyExit),
`endif
    .SadReady  (SadReady),
    .Busy      (Busy),
    .Done      (Done),
    .MinSad    (MinSad),
    .MinRow    (MinRow),
    .MinCol    (MinCol)
  );

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic pulse_start();
    Start = 1'b1;
    tick();
    Start = 1'b0;
  endtask

  task automatic send(input logic [SW-1:0] v, input int unsigned gap);
    SadValid = 1'b1;
    SadIn    = v;
    tick();
    SadValid = 1'b0;
    SadIn    = 16'hFFFF;
    for (int unsigned g = 0; g < gap; g++) tick();
  endtask

  // Compares the full result set against expected values.
  task automatic test_result(input string tag, input logic [SW-1:0] es, input logic er,
                             input logic [1:0] ec, input logic ed, input logic eb);
    vectors++;
    if (MinSad !== es) begin miscompares++; $display("FAIL %s MinSad got %0d want %0d", tag, MinSad, es); end
    vectors++;
    if (MinRow !== er) begin miscompares++; $display("FAIL %s MinRow got %0d want %0d", tag, MinRow, er); end
    vectors++;
    if (MinCol !== ec) begin miscompares++; $display("FAIL %s MinCol got %0d want %0d", tag, MinCol, ec); end
    vectors++;
    if (Done !== ed) begin miscompares++; $display("FAIL %s Done got %b want %b", tag, Done, ed); end
    vectors++;
    if (Busy !== eb) begin miscompares++; $display("FAIL %s Busy got %b want %b", tag, Busy, eb); end
  endtask

  task automatic test_reset();
    #2;
    vectors++;
    if (SadReady !== 1'b0) begin miscompares++; $display("FAIL rst SadReady got %b want 0", SadReady); end
    test_result("rst", 16'd0, 1'b0, 2'd0, 1'b0, 1'b0);
    @(negedge Clk);
    Reset = 1'b1;
    tick(); tick();
    Reset = 1'b0;  // reset pulse while idle
    #2;
    test_result("rst_idle", 16'd0, 1'b0, 2'd0, 1'b0, 1'b0);
    @(negedge Clk);
    Reset = 1'b1;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [SW-1:0] v [6] = '{16'd50, 16'd40, 16'd60, 16'd40, 16'd10, 16'd70};
    pulse_start();
    vectors++;
    if (SadReady !== 1'b1) begin miscompares++; $display("FAIL bb SadReady got %b want 1", SadReady); end
    test_result("bb_start", 16'd0, 1'b0, 2'd0, 1'b0, 1'b1);
    for (int unsigned i = 0; i < 6; i++) begin
      send(v[i], 0);
      if (i == 0) test_result("bb_first", 16'd50, 1'b0, 2'd0, 1'b0, 1'b1);
      if (i == 3) test_result("bb_tie", 16'd40, 1'b0, 2'd1, 1'b0, 1'b1);
    end
    test_result("bb_done", 16'd10, 1'b1, 2'd1, 1'b1, 1'b1);
    tick();
    test_result("bb_idle", 16'd10, 1'b1, 2'd1, 1'b0, 1'b0);
    vectors++;
    if (SadReady !== 1'b0) begin miscompares++; $display("FAIL bb_idle SadReady got %b want 0", SadReady); end
  endtask

  task automatic test_ties();
    pulse_start();
    for (int unsigned i = 0; i < 6; i++) send(16'd20, 0);
    test_result("tie_done", 16'd20, 1'b0, 2'd0, 1'b1, 1'b1);
    tick();
  endtask

  task automatic test_gaps();
    logic [SW-1:0] v [6] = '{16'd50, 16'd40, 16'd60, 16'd40, 16'd10, 16'd70};
    int unsigned   gp [6] = '{1, 0, 3, 2, 1, 0};
    int            base;
    // Valid data outside a scan must be ignored.
    SadValid = 1'b1; SadIn = 16'd1;
    tick();
    SadValid = 1'b0;
    test_result("gap_idlevalid", 16'd20, 1'b0, 2'd0, 1'b0, 1'b0);
    base = done_cnt;
    pulse_start();
    for (int unsigned i = 0; i < 6; i++) begin
      send(v[i], gp[i]);
      if (i == 2) pulse_start();
      if (i == 4) test_result("gap_mid", 16'd10, 1'b1, 2'd1, 1'b0, 1'b1);
    end
    test_result("gap_done", 16'd10, 1'b1, 2'd1, 1'b1, 1'b1);
    tick(); tick(); tick();
    vectors++;
    if (done_cnt - base !== 1) begin miscompares++; $display("FAIL gap_donecount got %0d want 1", done_cnt - base); end
    test_result("gap_idle", 16'd10, 1'b1, 2'd1, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_scan();
    logic [SW-1:0] v [6] = '{16'd9, 16'd8, 16'd7, 16'd6, 16'd5, 16'd4};
    pulse_start();
    send(16'd30, 0); send(16'd20, 0); send(16'd25, 0);
    Reset = 1'b0;
    #2;
    vectors++;
    if (SadReady !== 1'b0) begin miscompares++; $display("FAIL rstmid SadReady got %b want 0", SadReady); end
    test_result("rstmid", 16'd0, 1'b0, 2'd0, 1'b0, 1'b0);
    @(negedge Clk);
    Reset = 1'b1;
    tick();
    pulse_start();
    for (int unsigned i = 0; i < 6; i++) send(v[i], 0);
    test_result("rstmid_rescan", 16'd4, 1'b1, 2'd2, 1'b1, 1'b1);
    tick();
  endtask

`ifdef SAD_EARLY_EXIT_EN
  task automatic test_early_exit();
    Threshold = 16'd15;
    pulse_start();
    vectors++;
    if (EarlyExit !== 1'b0) begin miscompares++; $display("FAIL ee_start EarlyExit got %b want 0", EarlyExit); end
    send(16'd50, 0);
    send(16'd12, 0);
    test_result("ee_done", 16'd12, 1'b0, 2'd1, 1'b1, 1'b1);
    vectors++;
    if (EarlyExit !== 1'b1) begin miscompares++; $display("FAIL ee_done EarlyExit got %b want 1", EarlyExit); end
    tick();
    vectors++;
    if (EarlyExit !== 1'b1) begin miscompares++; $display("FAIL ee_idle EarlyExit got %b want 1", EarlyExit); end
    pulse_start();
    vectors++;
    if (EarlyExit !== 1'b0) begin miscompares++; $display("FAIL ee_restart EarlyExit got %b want 0", EarlyExit); end
    for (int unsigned i = 0; i < 5; i++) send(16'd40, 0);
    send(16'd3, 0);
    test_result("ee_last", 16'd3, 1'b1, 2'd2, 1'b1, 1'b1);
    vectors++;
    if (EarlyExit !== 1'b1) begin miscompares++; $display("FAIL ee_last EarlyExit got %b want 1", EarlyExit); end
    tick();
    Threshold = '0;
  endtask
`endif

  initial begin
    test_reset();
    test_back_to_back();
    test_ties();
    test_gaps();
    test_reset_mid_scan();
`ifdef SAD_EARLY_EXIT_EN
    test_early_exit();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running want finished");
    $fatal(1);
  end

endmodule
